jailbreak_bridge_decode: RTL and testbench
==========================================

JAILBREAK_BRIDGE_DECODE -- requirements
Module: jailbreak_bridge_decode

Interface
REQ-001 Parameter NUM_SLAVES, default 4, number of slave windows (1..16).
REQ-002 Parameter REGION, default 4'hF, required value of host_addr[31:28] for a decode hit.
REQ-003 Parameter TIMEOUT, default 16, cycles in WAIT before a read is abandoned.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 host_addr  input  32  host bridge address.
REQ-007 host_wr / host_rd  input  1 each  single-cycle write / read request strobes.
REQ-008 host_wr_data  input  32  host write data.
REQ-009 host_rd_data  output  32  read response data.
REQ-010 host_rd_data_valid  output  1  single-cycle read response strobe.
REQ-011 slv_addr / slv_wr_data  output  32 each  registered address / write data, shared by all slaves.
REQ-012 slv_wr / slv_rd  output  NUM_SLAVES each  one-hot per-slave write / read strobes.
REQ-013 slv_rd_data  input  NUM_SLAVES*32  slave i read data at bits [32*i+31:32*i].
REQ-014 slv_rd_data_valid  input  NUM_SLAVES  per-slave read response strobe.
REQ-015 err_count  output  8  saturating count of timeouts and dropped reads.

Function
REQ-016 Decode: mapped when host_addr[31:28]==REGION and host_addr[15:8]<NUM_SLAVES; slave index = host_addr[15:8]; otherwise unmapped.
REQ-017 Request at cycle N (mapped) -> matching slv_wr/slv_rd bit high for exactly cycle N+1; slv_addr, slv_wr_data registered in the same edge.
REQ-018 host_wr and host_rd together in one cycle -> both strobes to the same slave in the same cycle, subject to REQ-021.
REQ-019 Writes are accepted in every FSM state; unmapped writes produce no strobe and no error.
REQ-020 Read FSM states IDLE, WAIT; IDLE + mapped host_rd -> WAIT, latch index, clear timer.
REQ-021 host_rd while in WAIT -> dropped (no slv_rd), err_count increments.
REQ-022 WAIT: slv_rd_data_valid[latched index] -> host_rd_data <= that slave's data, host_rd_data_valid high one cycle later, state -> IDLE.
REQ-023 Valid strobes from non-latched slaves, or any valid in IDLE, are ignored.
REQ-024 WAIT timer increments every cycle; reaching TIMEOUT -> host_rd_data <= 32'hDEADDEAD, valid pulse, err_count increments, -> IDLE.
REQ-025 Slave valid in the timeout cycle wins: real data returned, no error counted.
REQ-026 Unmapped host_rd in IDLE -> host_rd_data 32'hFFFFFFFF with valid at N+1, no slave strobe, FSM stays IDLE.
REQ-027 err_count saturates at 255, never wraps.
REQ-028 host_rd_data holds its last value between responses; host_rd_data_valid never high two consecutive cycles.

Reset
REQ-029 reset asserted -> immediately: all outputs 0, FSM IDLE, timer 0, err_count 0.
REQ-030 reset during WAIT abandons the read; no response is ever issued for it after release.

Verification
REQ-031 Write addr 0xF0000200 data 0x12345678 -> slv_wr=4'b0100 one cycle at N+1, slv_wr_data 0x12345678; no error.
REQ-032 Read 0xF0000100, slave 1 valid 3 cycles later with 0xCAFEF00D -> host_rd_data 0xCAFEF00D, valid one cycle after slave valid.
REQ-033 Read 0xF0000000, slave silent -> 0xDEADDEAD valid after TIMEOUT cycles, err_count 1; second read during WAIT -> err_count 2.
REQ-034 Read 0x10000000 and 0xF0000500 (index>=4) -> 0xFFFFFFFF valid at N+1, no slv_rd, err_count unchanged.
REQ-035 Slave valid coincident with timeout -> real data, err_count unchanged; 300 forced timeouts -> err_count 255.
REQ-036 Reset asserted mid-WAIT, slave valid after release -> no host_rd_data_valid, all outputs 0.

Source files
------------

// File: rtl/jailbreak_bridge_decode.sv
// Host-to-slave bridge: decodes a host address window into one-hot slave strobes and returns single-outstanding reads.
// Latency: slave strobes 1 cycle after the host request; read response 1 cycle after slave valid, or TIMEOUT+1 cycles after request.
// Backpressure: none; a host read arriving while one is outstanding (or while a response strobe is being issued) is dropped and counted.
module jailbreak_bridge_decode #(
    parameter int         NUM_SLAVES = 4,
    parameter logic [3:0] REGION     = 4'hF,
    parameter int         TIMEOUT    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                host_addr,
    input  logic                       host_wr,
    input  logic                       host_rd,
    input  logic [31:0]                host_wr_data,
    output logic [31:0]                host_rd_data,
    output logic                       host_rd_data_valid,
    output logic [31:0]                slv_addr,
    output logic [31:0]                slv_wr_data,
    output logic [NUM_SLAVES-1:0]      slv_wr,
    output logic [NUM_SLAVES-1:0]      slv_rd,
    input  logic [NUM_SLAVES*32-1:0]   slv_rd_data,
    input  logic [NUM_SLAVES-1:0]      slv_rd_data_valid,
    output logic [7:0]                 err_count
);

    localparam int              IDX_W        = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int              TMR_W        = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT - 1);
    localparam logic [8:0]      NUM_SLAVES_W = 9'(NUM_SLAVES);
    localparam logic [31:0]     RD_TIMEOUT   = 32'hDEADDEAD;
    localparam logic [31:0]     RD_UNMAPPED  = 32'hFFFFFFFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Registered state and outputs
    state_t                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [TMR_W-1:0]        r_timer;
    logic [31:0]             r_host_rd_data;
    logic                    r_host_rd_data_valid;
    logic [31:0]             r_slv_addr;
    logic [31:0]             r_slv_wr_data;
    logic [NUM_SLAVES-1:0]   r_slv_wr;
    logic [NUM_SLAVES-1:0]   r_slv_rd;
    logic [7:0]              r_err_count;

    // Decode and control wires
    logic                    w_region_hit;
    logic [7:0]              w_idx;
    logic                    w_mapped;
    logic [NUM_SLAVES-1:0]   w_onehot;
    logic                    w_wr_accept;
    logic                    w_rd_accept;
    logic                    w_rd_unmapped;
    logic                    w_rd_drop;
    logic                    w_sel_vld;
    logic [31:0]             w_sel_dat;
    logic                    w_timeout;
    logic [1:0]              w_err_inc;
    logic [8:0]              w_err_sum;
    logic [7:0]              w_err_next;

    assign w_region_hit = (host_addr[31:28] == REGION);
    assign w_idx        = host_addr[15:8];
    assign w_mapped     = w_region_hit && ({1'b0, w_idx} < NUM_SLAVES_W);

    // One-hot slave select from the decoded index
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_onehot[i] = w_mapped && (w_idx == 8'(i));
        end
    end

    assign w_wr_accept   = host_wr && w_mapped;
    assign w_rd_accept   = host_rd && w_mapped && (r_state == ST_IDLE);
    // An unmapped read answered locally must not collide with a response strobe
    // already on the bus, otherwise the valid would be high two cycles running.
    assign w_rd_unmapped = host_rd && !w_mapped && (r_state == ST_IDLE) && !r_host_rd_data_valid;
    assign w_rd_drop     = host_rd && ((r_state == ST_WAIT) || (!w_mapped && r_host_rd_data_valid));

    // Pick the response of the slave the outstanding read was sent to
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_dat = 32'd0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sel_vld = slv_rd_data_valid[i];
                w_sel_dat = slv_rd_data[32*i +: 32];
            end
        end
    end

    // A slave answering in the last WAIT cycle beats the timeout
    assign w_timeout  = (r_state == ST_WAIT) && !w_sel_vld && (r_timer == TMR_LAST);

    // A dropped read and a timeout can land in the same cycle: count both, saturating
    assign w_err_inc  = {1'b0, w_rd_drop} + {1'b0, w_timeout};
    assign w_err_sum  = {1'b0, r_err_count} + {7'd0, w_err_inc};
    assign w_err_next = w_err_sum[8] ? 8'hFF : w_err_sum[7:0];

    // Write strobes and the shared address/data registers, accepted in any read state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slv_wr      <= '0;
            r_slv_addr    <= 32'd0;
            r_slv_wr_data <= 32'd0;
        end else begin
            r_slv_wr <= w_wr_accept ? w_onehot : '0;
            if (w_wr_accept || w_rd_accept) begin
                r_slv_addr    <= host_addr;
                r_slv_wr_data <= host_wr_data;
            end
        end
    end

    // Read FSM: one outstanding read, response/timeout handling and error counting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state              <= ST_IDLE;
            r_idx                <= '0;
            r_timer              <= '0;
            r_host_rd_data       <= 32'd0;
            r_host_rd_data_valid <= 1'b0;
            r_slv_rd             <= '0;
            r_err_count          <= 8'd0;
        end else begin
            r_slv_rd             <= w_rd_accept ? w_onehot : '0;
            r_host_rd_data_valid <= 1'b0;
            r_err_count          <= w_err_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_rd_accept) begin
                        r_state <= ST_WAIT;
                        r_idx   <= w_idx[IDX_W-1:0];
                        r_timer <= '0;
                    end else if (w_rd_unmapped) begin
                        r_host_rd_data       <= RD_UNMAPPED;
                        r_host_rd_data_valid <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (w_sel_vld) begin
                        r_host_rd_data       <= w_sel_dat;
                        r_host_rd_data_valid <= 1'b1;
                        r_state              <= ST_IDLE;
                    end else if (w_timeout) begin
                        r_host_rd_data       <= RD_TIMEOUT;
                        r_host_rd_data_valid <= 1'b1;
                        r_state              <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign host_rd_data       = r_host_rd_data;
    assign host_rd_data_valid = r_host_rd_data_valid;
    assign slv_addr           = r_slv_addr;
    assign slv_wr_data        = r_slv_wr_data;
    assign slv_wr             = r_slv_wr;
    assign slv_rd             = r_slv_rd;
    assign err_count          = r_err_count;

endmodule

// File: tb/tb_jailbreak_bridge_decode.sv
// Directed bench for jailbreak_bridge_decode: writes, reads, timeouts, drops, unmapped reads, saturation, reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Every expected value below is a hand-computed constant.
module tb_jailbreak_bridge_decode;

    localparam int TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  host_addr;
    logic         host_wr;
    logic         host_rd;
    logic [31:0]  host_wr_data;
    logic [31:0]  host_rd_data;
    logic         host_rd_data_valid;
    logic [31:0]  slv_addr;
    logic [31:0]  slv_wr_data;
    logic [3:0]   slv_wr;
    logic [3:0]   slv_rd;
    logic [127:0] slv_rd_data;
    logic [3:0]   slv_rd_data_valid;
    logic [7:0]   err_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jailbreak_bridge_decode #(
        .NUM_SLAVES (4),
        .REGION     (4'hF),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .host_addr          (host_addr),
        .host_wr            (host_wr),
        .host_rd            (host_rd),
        .host_wr_data       (host_wr_data),
        .host_rd_data       (host_rd_data),
        .host_rd_data_valid (host_rd_data_valid),
        .slv_addr           (slv_addr),
        .slv_wr_data        (slv_wr_data),
        .slv_wr             (slv_wr),
        .slv_rd             (slv_rd),
        .slv_rd_data        (slv_rd_data),
        .slv_rd_data_valid  (slv_rd_data_valid),
        .err_count          (err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_data"}, host_rd_data, 32'd0);
        chk({tag, "_rd_vld"},  {31'd0, host_rd_data_valid}, 32'd0);
        chk({tag, "_slv_addr"}, slv_addr, 32'd0);
        chk({tag, "_slv_wdat"}, slv_wr_data, 32'd0);
        chk({tag, "_slv_wr"},  {28'd0, slv_wr}, 32'd0);
        chk({tag, "_slv_rd"},  {28'd0, slv_rd}, 32'd0);
        chk({tag, "_err"},     {24'd0, err_count}, 32'd0);
    endtask

    initial begin
        reset             = 1'b1;
        host_addr         = 32'd0;
        host_wr           = 1'b0;
        host_rd           = 1'b0;
        host_wr_data      = 32'd0;
        slv_rd_data       = '0;
        slv_rd_data_valid = 4'b0000;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Mapped write to slave 2
        host_addr = 32'hF0000200; host_wr_data = 32'h12345678; host_wr = 1'b1;
        tick();
        host_wr = 1'b0;
        chk("wr_strobe", {28'd0, slv_wr}, 32'h4);
        chk("wr_data",   slv_wr_data, 32'h12345678);
        chk("wr_addr",   slv_addr, 32'hF0000200);
        chk("wr_no_rd",  {28'd0, slv_rd}, 32'h0);
        tick();
        chk("wr_one_cycle", {28'd0, slv_wr}, 32'h0);
        chk("wr_no_err",    {24'd0, err_count}, 32'd0);

        // Read from slave 1, answered 3 cycles after the request
        host_addr = 32'hF0000100; host_rd = 1'b1;
        tick();                                   // N+1
        host_rd = 1'b0;
        chk("rd1_strobe", {28'd0, slv_rd}, 32'h2);
        chk("rd1_addr",   slv_addr, 32'hF0000100);
        tick();                                   // N+2
        chk("rd1_strobe_gone", {28'd0, slv_rd}, 32'h0);
        tick();                                   // N+3
        slv_rd_data[63:32] = 32'hCAFEF00D; slv_rd_data_valid = 4'b0010;
        chk("rd1_no_early_vld", {31'd0, host_rd_data_valid}, 32'd0);
        tick();                                   // N+4
        slv_rd_data_valid = 4'b0000;
        chk("rd1_vld",  {31'd0, host_rd_data_valid}, 32'd1);
        chk("rd1_data", host_rd_data, 32'hCAFEF00D);
        tick();
        chk("rd1_vld_single", {31'd0, host_rd_data_valid}, 32'd0);
        chk("rd1_data_hold",  host_rd_data, 32'hCAFEF00D);

        // Read from silent slave 0; a non-selected slave answers and is ignored
        host_addr = 32'hF0000000; host_rd = 1'b1;
        tick();                                   // N+1
        host_rd = 1'b0;
        chk("to_strobe", {28'd0, slv_rd}, 32'h1);
        slv_rd_data[95:64] = 32'h99998888; slv_rd_data_valid = 4'b0100;
        tick();                                   // N+2
        slv_rd_data_valid = 4'b0000;
        for (int k = 3; k <= TIMEOUT; k++) tick();  // N+TIMEOUT
        chk("to_no_early_vld", {31'd0, host_rd_data_valid}, 32'd0);
        tick();                                   // N+TIMEOUT+1
        chk("to_vld",  {31'd0, host_rd_data_valid}, 32'd1);
        chk("to_data", host_rd_data, 32'hDEADDEAD);
        chk("to_err",  {24'd0, err_count}, 32'd1);
        tick();
        chk("to_vld_single", {31'd0, host_rd_data_valid}, 32'd0);

        // Second read while one is outstanding is dropped
        host_addr = 32'hF0000000; host_rd = 1'b1;
        tick();                                   // N+1
        host_rd = 1'b0;
        tick();                                   // N+2
        host_addr = 32'hF0000100; host_rd = 1'b1;
        tick();                                   // N+3
        host_rd = 1'b0;
        chk("drop_no_strobe", {28'd0, slv_rd}, 32'h0);
        chk("drop_err",       {24'd0, err_count}, 32'd2);
        chk("drop_addr_kept", slv_addr, 32'hF0000000);
        slv_rd_data[31:0] = 32'h11112222; slv_rd_data_valid = 4'b0001;
        tick();                                   // N+4
        slv_rd_data_valid = 4'b0000;
        chk("drop_resp_vld",  {31'd0, host_rd_data_valid}, 32'd1);
        chk("drop_resp_data", host_rd_data, 32'h11112222);
        tick();

        // Simultaneous write and read to slave 3; slave answers in the first WAIT cycle
        host_addr = 32'hF0000300; host_wr_data = 32'hA5A5A5A5; host_wr = 1'b1; host_rd = 1'b1;
        tick();                                   // N+1
        host_wr = 1'b0; host_rd = 1'b0;
        chk("wrrd_wr", {28'd0, slv_wr}, 32'h8);
        chk("wrrd_rd", {28'd0, slv_rd}, 32'h8);
        slv_rd_data[127:96] = 32'h33334444; slv_rd_data_valid = 4'b1000;
        tick();                                   // N+2
        slv_rd_data_valid = 4'b0000;
        chk("wrrd_vld",  {31'd0, host_rd_data_valid}, 32'd1);
        chk("wrrd_data", host_rd_data, 32'h33334444);
        tick();

        // Unmapped reads: wrong region, then index beyond the slave count
        host_addr = 32'h10000000; host_rd = 1'b1;
        tick();
        host_rd = 1'b0;
        chk("unm1_vld",   {31'd0, host_rd_data_valid}, 32'd1);
        chk("unm1_data",  host_rd_data, 32'hFFFFFFFF);
        chk("unm1_no_rd", {28'd0, slv_rd}, 32'h0);
        tick();
        host_addr = 32'hF0000500; host_rd = 1'b1;
        tick();
        host_rd = 1'b0;
        chk("unm2_vld",   {31'd0, host_rd_data_valid}, 32'd1);
        chk("unm2_data",  host_rd_data, 32'hFFFFFFFF);
        chk("unm2_no_rd", {28'd0, slv_rd}, 32'h0);
        chk("unm2_err",   {24'd0, err_count}, 32'd2);
        host_wr = 1'b1; host_wr_data = 32'h0BADBEEF;
        tick();
        host_wr = 1'b0;
        chk("unm_wr_no_strobe", {28'd0, slv_wr}, 32'h0);
        chk("unm_wr_no_err",    {24'd0, err_count}, 32'd2);
        tick();

        // Slave answers in the very cycle the timer would expire
        host_addr = 32'hF0000200; host_rd = 1'b1;
        tick();                                   // N+1
        host_rd = 1'b0;
        for (int k = 2; k <= TIMEOUT; k++) tick();  // N+TIMEOUT
        slv_rd_data[95:64] = 32'h5A5A1234; slv_rd_data_valid = 4'b0100;
        tick();
        slv_rd_data_valid = 4'b0000;
        chk("race_vld",  {31'd0, host_rd_data_valid}, 32'd1);
        chk("race_data", host_rd_data, 32'h5A5A1234);
        chk("race_err",  {24'd0, err_count}, 32'd2);
        tick();

        // 300 forced timeouts saturate the error counter
        host_addr = 32'hF0000000;
        for (int n = 0; n < 300; n++) begin
            host_rd = 1'b1;
            tick();
            host_rd = 1'b0;
            repeat (TIMEOUT) tick();
            if (n == 252) chk("sat_reach_255", {24'd0, err_count}, 32'd255);
        end
        chk("sat_vld",  {31'd0, host_rd_data_valid}, 32'd1);
        chk("sat_data", host_rd_data, 32'hDEADDEAD);
        chk("sat_err",  {24'd0, err_count}, 32'd255);
        tick();

        // Reset in the middle of an outstanding read
        host_addr = 32'hF0000100; host_rd = 1'b1;
        tick();
        host_rd = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("rst_async");
        tick();
        reset = 1'b0;
        slv_rd_data[63:32] = 32'h77776666; slv_rd_data_valid = 4'b0010;
        tick();
        slv_rd_data_valid = 4'b0000;
        chk("rst_no_resp", {31'd0, host_rd_data_valid}, 32'd0);
        tick();
        check_all_zero("rst_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
